// File: rtl/result_outbus_tx.sv
// result_outbus_tx: serialises a captured {A,Q} result onto a w-bit bus, least significant word first; out_par with RESULT_OUTBUS_PARITY_EN.
// Latency: word 0 is valid the cycle after start; with out_ready high, N beats then one done cycle.
// Backpressure: out_ready low freezes outbus, out_valid, the shift register and the beat count indefinitely.
module result_outbus_tx #(
   parameter int w  = 16,
   parameter int RW = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [RW/2-1:0] a_in,
   input  logic [RW/2-1:0] q_in,
   input  logic            out_ready,
   output logic [w-1:0]    outbus,
   output logic            out_valid,
   output logic            busy,
   output logic            done
`ifdef RESULT_OUTBUS_PARITY_EN
   ,
   output logic            out_par
`endif
);

   localparam int N  = RW / w;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] shreg, shreg_nxt;
   logic [CW-1:0] beat_cnt, beat_cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // Outputs decode registered state only, so neither start nor out_ready reaches them combinationally.
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      beat_cnt_nxt = beat_cnt;
      outbus       = '0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_nxt    = {a_in, q_in};
               beat_cnt_nxt = '0;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            outbus    = shreg[w-1:0];
            if (out_ready) begin
               shreg_nxt = shreg >> w;
               // Terminal beat leaves the counter at N-1 so it never wraps mid-transfer.
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt = DONE;
               end else begin
                  beat_cnt_nxt = beat_cnt + 1'b1;
               end
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef RESULT_OUTBUS_PARITY_EN
   // outbus is already zero whenever out_valid is low, so parity is zero there too.
   assign out_par = ^outbus;
`endif

endmodule
